// File: rtl/camera_pkg.sv
// camera_pkg
// Shared definitions for the OV7670 SCCB configuration sequencer:
// table marker words, the default SCCB write address, the sequencer state
// encoding and the ACK-slot helper used when serialising a write.
package camera_pkg;

    localparam logic [15:0] END_MARK       = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK     = 16'hFFF0;
    localparam logic [7:0]  DEV_ID_DEFAULT = 8'h42;
    localparam logic [4:0]  SLOT_LAST      = 5'd26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DELAY,
        S_FINISH,
        S_START,
        S_SEND,
        S_STOP,
        S_GAP
    } state_t;

    // The ninth slot of each 9-bit phase is the don't-care/ACK bit; the
    // master releases the line there and never looks at the answer.
    function automatic logic is_ack_slot(input logic [4:0] slot);
        return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
    endfunction

endpackage

// File: rtl/camera_config_rom.sv
// camera_config_rom
// Registered constant table of {reg_addr, reg_data} words for the OV7670.
// dout is valid one clock after addr is applied. TEST_TABLE selects a
// four-entry table used for simulation of the sequencer.
//   clk  : system clock
//   addr : table entry number
//   dout : table word for addr, one cycle later
module camera_config_rom #(
    parameter bit TEST_TABLE = 1'b0
) (
    input  logic        clk,
    input  logic [7:0]  addr,
    output logic [15:0] dout
);

    logic [15:0] word;

    always_comb begin
        word = 16'hFFFF;
        if (TEST_TABLE) begin
            case (addr)
                8'd0:    word = 16'h1280;
                8'd1:    word = 16'hFFF0;
                8'd2:    word = 16'h1204;
                default: word = 16'hFFFF;
            endcase
        end else begin
            case (addr)
                8'd0:    word = 16'h1280;   // COM7: reset all registers
                8'd1:    word = 16'hFFF0;   // let the reset settle
                8'd2:    word = 16'h1204;   // COM7: RGB output
                8'd3:    word = 16'h40D0;   // COM15: RGB565, full range
                8'd4:    word = 16'h1101;   // CLKRC: prescale by 2
                8'd5:    word = 16'h0C00;   // COM3: no scaling
                8'd6:    word = 16'h3E00;   // COM14: normal PCLK
                8'd7:    word = 16'h8C00;   // RGB444 disabled
                8'd8:    word = 16'h3A04;   // TSLB: output sequence
                8'd9:    word = 16'h1438;   // COM9: AGC ceiling
                8'd10:   word = 16'h4FB3;   // MTX1..MTX6 colour matrix
                8'd11:   word = 16'h50B3;
                8'd12:   word = 16'h5100;
                8'd13:   word = 16'h523D;
                8'd14:   word = 16'h53A7;
                8'd15:   word = 16'h54E4;
                8'd16:   word = 16'h589E;   // MTXS: matrix sign
                8'd17:   word = 16'h3DC0;   // COM13: gamma and UV saturation
                default: word = 16'hFFFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        dout <= word;
    end

endmodule

// File: rtl/camera_configure.sv
// camera_configure
// Walks the configuration table and issues one 3-phase SCCB write per
// entry (DEV_ID, addr, data), honouring delay markers and stopping at the
// end marker. All bus outputs are registered.
//   clk, reset : system clock, synchronous active-high reset
//   start      : pulse; begins the sequence at entry 0 when not busy
//   sioc       : SCCB clock
//   siod_out   : SCCB data value, siod_oe = 1 drives it, 0 releases the pad
//   busy, done : sequence running / sequence finished (level)
//   index      : current table entry
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | bus released, waiting for start
// S_LOAD   | two cycles: ROM read latency, then decode the table word
// S_DELAY  | bus released for DELAY_CYCLES, then next entry
// S_FINISH | one cycle; raises done and drops busy on exit
// S_START  | 2 quarters: SIOD low under high SIOC, then SIOC low
// S_SEND   | 27 slots of 4 quarters, MSB first, X slots released
// S_STOP   | 3 quarters: SIOD low, SIOC high, SIOD released
// S_GAP    | 4 quarters of bus-free time, then next entry
module camera_configure
    import camera_pkg::*;
#(
    parameter int          QUARTER      = 63,
    parameter int          DELAY_CYCLES = 250000,
    parameter logic [7:0]  DEV_ID       = DEV_ID_DEFAULT,
    parameter bit          TEST_TABLE   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] index
);

    localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int DW = ($clog2(DELAY_CYCLES) > 18) ? $clog2(DELAY_CYCLES) : 18;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      ph_q, ph_d;
    logic [4:0]      slot_q, slot_d;
    logic [DW-1:0]   dly_q, dly_d;
    logic            ld_q, ld_d;
    logic [7:0]      index_q, index_d;
    logic [15:0]     word_q, word_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            sioc_q, sioc_d, siod_q, siod_d, oe_q, oe_d;
    logic            q_end;
    logic [15:0]     rom_dout;
    logic [26:0]     frame;

    camera_config_rom #(.TEST_TABLE(TEST_TABLE)) u_rom (
        .clk  (clk),
        .addr (index_q),
        .dout (rom_dout)
    );

    assign q_end = (qcnt_q == QW'(QUARTER - 1));

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        ph_d    = ph_q;
        slot_d  = slot_q;
        dly_d   = dly_q;
        ld_d    = ld_q;
        index_d = index_q;
        word_d  = word_q;
        busy_d  = busy_q;
        done_d  = done_q;

        // Quarter states share the quarter counter; it always ends at 0.
        if (state_q == S_START || state_q == S_SEND ||
            state_q == S_STOP  || state_q == S_GAP) begin
            qcnt_d = q_end ? '0 : qcnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    ld_d    = 1'b0;
                    index_d = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (!ld_q) begin
                    ld_d = 1'b1;
                end else begin
                    ld_d   = 1'b0;
                    qcnt_d = '0;
                    ph_d   = 2'd0;
                    dly_d  = '0;
                    if (index_q == 8'hFF || rom_dout == END_MARK) begin
                        state_d = S_FINISH;
                    end else if (rom_dout == DELAY_MARK) begin
                        state_d = S_DELAY;
                    end else begin
                        state_d = S_START;
                        word_d  = rom_dout;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == DW'(DELAY_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    index_d = index_q + 8'd1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_START: begin
                if (q_end) begin
                    if (ph_q == 2'd1) begin
                        state_d = S_SEND;
                        ph_d    = 2'd0;
                        slot_d  = 5'd0;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
            S_SEND: begin
                if (q_end) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        if (slot_q == SLOT_LAST) state_d = S_STOP;
                        else                     slot_d  = slot_q + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (q_end) begin
                    if (ph_q == 2'd2) begin
                        state_d = S_GAP;
                        ph_d    = 2'd0;
                    end else begin
                        ph_d = ph_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (q_end) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        state_d = S_LOAD;
                        ld_d    = 1'b0;
                        index_d = index_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus pins are derived from the next state so they register in step
    // with it; data therefore only changes together with slot_d at q0.
    always_comb begin
        frame    = {DEV_ID, 1'b1, word_d[15:8], 1'b1, word_d[7:0], 1'b1};
        sioc_d   = 1'b1;
        siod_d   = 1'b1;
        oe_d     = 1'b0;
        case (state_d)
            S_START: begin
                sioc_d = (ph_d == 2'd0);
                siod_d = 1'b0;
                oe_d   = 1'b1;
            end
            S_SEND: begin
                sioc_d = ph_d[1];
                siod_d = frame[SLOT_LAST - slot_d];
                oe_d   = !is_ack_slot(slot_d);
            end
            S_STOP: begin
                sioc_d = (ph_d != 2'd0);
                siod_d = (ph_d == 2'd2);
                oe_d   = (ph_d != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            ph_q    <= 2'd0;
            slot_q  <= 5'd0;
            dly_q   <= '0;
            ld_q    <= 1'b0;
            index_q <= 8'd0;
            word_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            ph_q    <= ph_d;
            slot_q  <= slot_d;
            dly_q   <= dly_d;
            ld_q    <= ld_d;
            index_q <= index_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sioc_q  <= sioc_d;
            siod_q  <= siod_d;
            oe_q    <= oe_d;
        end
    end

    assign sioc     = sioc_q;
    assign siod_out = siod_q;
    assign siod_oe  = oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign index    = index_q;

endmodule
